breath_mode_ctrl: RTL
=====================

// Module: breath_mode_ctrl
// PURPOSE
//  Mode sequencer for the breathing-LED banks (slow / mid / fast / afk1 / afk2).
//  - Debounces one user key; each press advances the active breathing mode.
//  - After a user-idle timeout, enters AFK display, alternating between the
//    afk1 and afk2 patterns.
//  - Drives one-hot enables and a restart pulse to the breath modules; the
//    board top muxes LED pins with mode_en.
// PARAMETERS
//  DEB_CYCLES       240000     key must be stable this long (20 ms @ 12 MHz)
//  IDLE_CYCLES      360000000  cycles without a press before AFK (30 s)
//  AFK_SWAP_CYCLES  48000000   dwell per AFK pattern before toggling (4 s)
//  CLR_CYCLES       4          length of mode_rst_n low pulse after a change
//  Constraints: all >= 1; IDLE_CYCLES > DEB_CYCLES.
// PORTS
//  clk         in   1  system clock, 12 MHz
//  rst         in   1  asynchronous, active-low reset
//  key_n       in   1  raw user key, active-low, asynchronous to clk, bouncy
//  mode_en     out  5  one-hot enable: [0]slow [1]mid [2]fast [3]afk1 [4]afk2
//  mode_code   out  3  binary state code, 0..4 (same order as mode_en)
//  afk         out  1  high while in AFK1 or AFK2
//  mode_rst_n  out  1  active-low restart for breath modules (cnt1/cnt2/flag)
// BEHAVIOUR
//  Reset values:
//   - state = SLOW, last_active = SLOW, idle_cnt = 0, swap_cnt = 0.
//   - mode_en = 5'b00001, mode_code = 0, afk = 0, mode_rst_n = 0.
//   - After rst releases, mode_rst_n stays low CLR_CYCLES cycles, then goes 1.
//  Key path:
//   - key_n passes a 2-flop synchroniser; the debounced level updates only
//     after DEB_CYCLES consecutive equal samples.
//   - key_evt: 1-cycle pulse on the debounced 1->0 edge. A held key gives
//     exactly one event; bounce on release gives none.
//   - Latency: key_n stable low -> key_evt at 2 + DEB_CYCLES edges.
//  FSM (registered; outputs decode the state register, so they change on the
//  edge after key_evt or the terminal count):
//   SLOW/MID/FAST:
//    - key_evt -> next in ring SLOW->MID->FAST->SLOW; idle_cnt <= 0.
//    - No key_evt: idle_cnt++. When idle_cnt == IDLE_CYCLES-1 -> AFK1;
//      last_active <= current state; swap_cnt <= 0.
//   AFK1/AFK2:
//    - swap_cnt++. When swap_cnt == AFK_SWAP_CYCLES-1 -> toggle AFK1<->AFK2;
//      swap_cnt <= 0.
//    - key_evt -> last_active (a wake press does not advance the mode);
//      idle_cnt <= 0.
//  Simultaneous events:
//   - key_evt in the same cycle as an idle or swap terminal count: key wins.
//  Restart pulse:
//   - Every state change (including AFK toggles) drives mode_rst_n low for
//     CLR_CYCLES cycles, starting the same edge the state changes.
//   - A change inside an active pulse reloads the pulse counter.
//  Counter widths: $clog2(PARAM) bits; compare to PARAM-1 only, no wrap needed.
//  Reset mid-operation: all registers return to reset values immediately;
//  any pending debounce count is discarded.
// STRUCTURE
//  breath_pkg:
//   - localparams MODE_SLOW=0, MODE_MID=1, MODE_FAST=2, MODE_AFK1=3, MODE_AFK2=4
//   - MODE_W=3, NUM_MODES=5
//   - shared with the board top mux.
//  Sub-module key_debounce (clk, rst, key_n -> key_lvl, key_evt):
//   - synchroniser, debounce counter and edge pulse.
//   - parameter DEB_CYCLES.
//  FSM, idle/swap counters and restart-pulse logic stay in this module.
// TESTING  (bench params: DEB=4, IDLE=50, SWAP=20, CLR=3)
//  1. Reset release -> mode_en=00001, mode_code=0, afk=0; mode_rst_n=0 for 3
//     cycles, then 1.
//  2. key_n toggles every 2 cycles for 10 cycles, then held low -> exactly one
//     SLOW->MID, at 6 edges after the final low plus one; mode_rst_n low 3
//     cycles.
//  3. Three clean presses -> MID, FAST, SLOW (wrap). Key held 100 cycles ->
//     no further advance.
//  4. From FAST, 50 idle cycles -> AFK1 (code 3, afk=1); +20 cycles -> AFK2
//     (code 4); +20 cycles -> AFK1. Pulse on each change.
//  5. Press during AFK2 -> FAST (code 2, afk=0); idle counter restarts from 0
//     (AFK again only after 50 more idle cycles).
//  6. key_evt aligned with the idle terminal count -> ring advances, no AFK.
//     rst low mid-AFK2 -> mode_en=00001 in the same cycle, without a clock.

Source files
------------

// File: rtl/breath_pkg.sv
// breath_pkg: mode codes and state type shared by the mode sequencer and the board LED mux.
package breath_pkg;
  localparam int MODE_W = 3;
  localparam int NUM_MODES = 5;
  localparam logic [MODE_W-1:0] MODE_SLOW = 3'd0, MODE_MID = 3'd1, MODE_FAST = 3'd2, MODE_AFK1 = 3'd3, MODE_AFK2 = 3'd4;
  typedef enum logic [MODE_W-1:0] {
    S_SLOW = MODE_SLOW, S_MID = MODE_MID, S_FAST = MODE_FAST, S_AFK1 = MODE_AFK1, S_AFK2 = MODE_AFK2
  } mode_t;
  // counter width for a count of n, never zero bits
  function automatic int cnt_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/breath_mode_ctrl_if.sv
// breath_mode_ctrl_if: user key in, mode enables/code/restart out.
interface breath_mode_ctrl_if;
  import breath_pkg::*;
  logic key_n;
  logic [NUM_MODES-1:0] mode_en;
  logic [MODE_W-1:0] mode_code;
  logic afk;
  logic mode_rst_n;
  modport master (output key_n, input mode_en, mode_code, afk, mode_rst_n);
  modport slave (input key_n, output mode_en, mode_code, afk, mode_rst_n);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronises a bouncy active-low key and pulses once per debounced press.
module key_debounce #(
  parameter int DEB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic key_evt_o
);
  import breath_pkg::*;
  localparam int CW = cnt_w(DEB_CYCLES);
  logic [1:0] sync_q;
  logic lvl_q, evt_q;
  logic [CW-1:0] cnt_q;
  logic done;
  assign done = cnt_q == CW'(DEB_CYCLES - 1);
  // counter runs only while the synchronised sample disagrees with the accepted level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      lvl_q  <= 1'b1;
      cnt_q  <= '0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
      evt_q  <= 1'b0;
      if (sync_q[1] == lvl_q) cnt_q <= '0;
      else if (done) begin
        lvl_q <= sync_q[1];
        cnt_q <= '0;
        evt_q <= !sync_q[1];
      end else cnt_q <= cnt_q + 1'b1;
    end
  end
  assign key_evt_o = evt_q;
endmodule

// File: rtl/breath_mode_ctrl.sv
// breath_mode_ctrl: key-driven breathing-mode ring with idle timeout into alternating AFK patterns.
module breath_mode_ctrl
  import breath_pkg::*;
#(
  parameter int DEB_CYCLES      = 240000,
  parameter int IDLE_CYCLES     = 360000000,
  parameter int AFK_SWAP_CYCLES = 48000000,
  parameter int CLR_CYCLES      = 4
) (
  input logic clk,
  input logic rst,
  breath_mode_ctrl_if.slave bus
);
  localparam int IW = cnt_w(IDLE_CYCLES);
  localparam int SW = cnt_w(AFK_SWAP_CYCLES);
  localparam int CW = cnt_w(CLR_CYCLES);
  logic key_evt;
  mode_t state_q, state_d, last_q, last_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [SW-1:0] swap_q, swap_d;
  logic [CW-1:0] clr_q;
  logic rst_n_q, afk_q;
  logic [NUM_MODES-1:0] en_q;
  logic [MODE_W-1:0] code_q;
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk), .rst(rst), .key_n_i(bus.key_n), .key_evt_o(key_evt)
  );
  // a key event outranks either terminal count in the same cycle
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idle_d  = idle_q;
    swap_d  = swap_q;
    if (state_q == S_AFK1 || state_q == S_AFK2) begin
      swap_d = swap_q + 1'b1;
      if (key_evt) begin
        state_d = last_q;
        idle_d  = '0;
      end else if (swap_q == SW'(AFK_SWAP_CYCLES - 1)) begin
        state_d = state_q == S_AFK1 ? S_AFK2 : S_AFK1;
        swap_d  = '0;
      end
    end else if (key_evt) begin
      state_d = state_q == S_SLOW ? S_MID : state_q == S_MID ? S_FAST : S_SLOW;
      idle_d  = '0;
    end else if (idle_q == IW'(IDLE_CYCLES - 1)) begin
      state_d = S_AFK1;
      last_d  = state_q;
      swap_d  = '0;
    end else idle_d = idle_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_SLOW;
      last_q  <= S_SLOW;
      idle_q  <= '0;
      swap_q  <= '0;
      clr_q   <= CW'(CLR_CYCLES - 1);
      rst_n_q <= 1'b0;
      en_q    <= NUM_MODES'(1);
      code_q  <= MODE_SLOW;
      afk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idle_q  <= idle_d;
      swap_q  <= swap_d;
      en_q    <= NUM_MODES'(1) << state_d;
      code_q  <= state_d;
      afk_q   <= state_d == S_AFK1 || state_d == S_AFK2;
      if (state_d != state_q) begin
        clr_q   <= CW'(CLR_CYCLES - 1);
        rst_n_q <= 1'b0;
      end else if (clr_q != '0) begin
        clr_q   <= clr_q - 1'b1;
        rst_n_q <= 1'b0;
      end else rst_n_q <= 1'b1;
    end
  end
  assign bus.mode_en    = en_q;
  assign bus.mode_code  = code_q;
  assign bus.afk        = afk_q;
  assign bus.mode_rst_n = rst_n_q;
endmodule
